plot_grid_shadow: RTL and testbench

Receiving end of the pixel-plot stream that drawing FSMs drive into `vga_adapter`. It taps the same `x`/`y`/`colour`/`plot` signals and reduces every pixel write to a cell-level occupancy map. The map has 16×12 cells of 10×10 pixels. Game logic reads the map back through a request/acknowledge query port for collision and apple-placement checks, so it never has to read the framebuffer.

---
 rtl/plot_grid_shadow.sv | 137 +++++++++++++
 tb/tb_plot_grid_shadow.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/plot_grid_shadow.sv
`timescale 1ns/1ps
// plot_grid_shadow
// Cell-level occupancy shadow of the pixel-plot stream feeding vga_adapter.
// Every in-range pixel write sets (non-background colour) or clears
// (background colour) the bit of the 10x10 cell it lands in. Game logic
// queries single cells through a q_req/q_ack port.
//
// Handshake: q_req is held high with q_cx/q_cy stable until q_ack; a request
// is taken only in IDLE, and q_ack is high for exactly the one RESP cycle that
// follows, with q_hit valid in that cycle (q_hit holds its value afterwards).
//
// Optional feature macro: PLOT_GRID_COUNT_EN builds the occ_count counter;
// without it occ_count is tied to zero.
module plot_grid_shadow #(
  parameter int         XSCREEN = 160,
  parameter int         YSCREEN = 120,
  parameter int         CELL    = 10,
  parameter logic [2:0] BG      = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  input  logic       clr,
  input  logic       q_req,
  input  logic [3:0] q_cx,
  input  logic [3:0] q_cy,
  output logic       q_ack,
  output logic       q_hit,
  output logic       busy,
  output logic [7:0] occ_count,
  output logic [1:0] state_dbg
);

  localparam int NCX   = XSCREEN / CELL;
  localparam int NCY   = YSCREEN / CELL;
  localparam int NCELL = NCX * NCY;
  localparam logic [7:0] LAST_IDX = 8'(NCELL - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [7:0]       idx;
  logic [NCELL-1:0] map;

  logic       wr_en;
  logic       wr_bit;
  logic [7:0] wr_cell;
  logic       q_oob;
  logic [7:0] q_cell;
  logic       accept;

  // Decode the pixel write into a cell index; the write path is dead while clearing.
  always_comb begin
    wr_en   = plot && (state != S_CLEAR) && (int'(x) < XSCREEN) && (int'(y) < YSCREEN);
    wr_bit  = (colour != BG);
    wr_cell = 8'((int'(y) / CELL) * NCX + int'(x) / CELL);
  end

  // Query address decode; anything outside the grid reads as wall.
  always_comb begin
    q_oob  = (int'(q_cx) >= NCX) || (int'(q_cy) >= NCY);
    q_cell = 8'(int'(q_cy) * NCX + int'(q_cx));
    accept = (state == S_IDLE) && !clr && q_req;
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= S_CLEAR;
    else         state <= next_state;
  end

  // Next-state logic; clr beats q_req in IDLE, and RESP always completes.
  always_comb begin
    next_state = state;
    case (state)
      S_CLEAR: if (idx == LAST_IDX) next_state = S_IDLE;
      S_IDLE: begin
        if (clr)        next_state = S_CLEAR;
        else if (q_req) next_state = S_RESP;
      end
      S_RESP:  next_state = clr ? S_CLEAR : S_IDLE;
      default: next_state = S_CLEAR;
    endcase
  end

  // Clear index: counts through the map while clearing, parked at zero otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn)                                  idx <= 8'd0;
    else if (state == S_CLEAR && idx != LAST_IDX) idx <= idx + 8'd1;
    else                                          idx <= 8'd0;
  end

  // Occupancy storage: one bit cleared per cycle in CLEAR, else pixel writes.
  always_ff @(posedge CLOCK_50) begin
    if (resetn) begin
      if (state == S_CLEAR) map[idx]     <= 1'b0;
      else if (wr_en)       map[wr_cell] <= wr_bit;
    end
  end

  // Capture the query result; map is read before this edge's write (read-old).
  always_ff @(posedge CLOCK_50) begin
    if (!resetn)     q_hit <= 1'b0;
    else if (accept) q_hit <= q_oob ? 1'b1 : map[q_cell];
  end

`ifdef PLOT_GRID_COUNT_EN
  logic wr_change;

  // A write only moves the count when it actually flips the stored bit.
  always_comb begin
    wr_change = wr_en && (map[wr_cell] != wr_bit);
  end

  // Occupied-cell counter; zeroed on entry to and throughout CLEAR.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn)                      occ_count <= 8'd0;
    else if (state == S_CLEAR || clr) occ_count <= 8'd0;
    else if (wr_change)               occ_count <= wr_bit ? occ_count + 8'd1 : occ_count - 8'd1;
  end
`else
  assign occ_count = 8'd0;
`endif

  assign q_ack     = (state == S_RESP);
  assign busy      = (state == S_CLEAR);
  assign state_dbg = state;

endmodule

// File: tb/tb_plot_grid_shadow.sv
`timescale 1ns/1ps
// Directed bench for plot_grid_shadow: reset/clear timing, cell set/clear,
// range rejection, read-old collision, clear with a held query, reset mid-clear.
module tb_plot_grid_shadow;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       clr;
  logic       q_req;
  logic [3:0] q_cx;
  logic [3:0] q_cy;
  logic       q_ack;
  logic       q_hit;
  logic       busy;
  logic [7:0] occ_count;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  plot_grid_shadow dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .clr      (clr),
    .q_req    (q_req),
    .q_cx     (q_cx),
    .q_cy     (q_cy),
    .q_ack    (q_ack),
    .q_hit    (q_hit),
    .busy     (busy),
    .occ_count(occ_count),
    .state_dbg(state_dbg)
  );

  // clock
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] occ_exp(input int n);
`ifdef PLOT_GRID_COUNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Drivers start and end at #1 after a rising edge.
  task automatic plot_px(input logic [7:0] px, input logic [6:0] py, input logic [2:0] c);
    x = px; y = py; colour = c; plot = 1'b1;
    @(posedge CLOCK_50); #1;
    plot = 1'b0;
  endtask

  task automatic wait_ack(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge CLOCK_50);
      lat++;
    end while (!q_ack && lat < 400);
    if (!q_ack) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic finish_query(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead;
    check({tag, "_hit"}, 32'(q_hit), e);
    @(posedge CLOCK_50); #1;
    q_req = 1'b0;
    check({tag, "_ack_one_cycle"}, 32'(q_ack), 32'd0);
  endtask

  task automatic query(input logic [3:0] cx, input logic [3:0] cy, input logic e, input string tag);
    int lat;
    q_cx = cx; q_cy = cy; q_req = 1'b1;
    exp_q.push_back(32'(e));
    wait_ack(tag, lat);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    finish_query(tag);
  endtask

  // Counts cycles with busy high, sampled on falling edges; ends on the first idle cycle.
  task automatic count_busy(input bit poke, output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLOCK_50);
      plot = 1'b0;
      if (!busy) break;
      n++;
      if (poke && n == 10) begin
        x = 8'd0; y = 7'd0; colour = 3'b111; plot = 1'b1;
      end
    end
  endtask

  int n;
  int lat;

  initial begin
    resetn = 1'b0; x = '0; y = '0; colour = '0; plot = 1'b0;
    clr = 1'b0; q_req = 1'b0; q_cx = '0; q_cy = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_busy",  32'(busy), 32'd1);
    check("rst_ack",   32'(q_ack), 32'd0);
    check("rst_hit",   32'(q_hit), 32'd0);
    check("rst_occ",   32'(occ_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    resetn = 1'b1;
    count_busy(1'b0, n);
    check("rst_busy_len", 32'(n), 32'd192);
    @(posedge CLOCK_50); #1;

    query(4'd3, 4'd4, 1'b0, "q34_empty");
    check("occ_after_reset", 32'(occ_count), occ_exp(0));

    plot_px(8'd80, 7'd60, 3'b010);
    query(4'd8, 4'd6, 1'b1, "q86_set");
    check("occ_one", 32'(occ_count), occ_exp(1));

    colour = 3'b010; plot = 1'b1;
    for (int yy = 60; yy < 70; yy++) begin
      for (int xx = 80; xx < 90; xx++) begin
        x = 8'(xx); y = 7'(yy);
        @(posedge CLOCK_50); #1;
      end
    end
    plot = 1'b0;
    check("occ_same_cell", 32'(occ_count), occ_exp(1));
    query(4'd8, 4'd6, 1'b1, "q86_still");
    query(4'd7, 4'd6, 1'b0, "q76_left");
    query(4'd9, 4'd6, 1'b0, "q96_right");
    query(4'd8, 4'd7, 1'b0, "q87_below");

    plot_px(8'd85, 7'd65, 3'b000);
    query(4'd8, 4'd6, 1'b0, "q86_erased");
    check("occ_zero", 32'(occ_count), occ_exp(0));
    query(4'd5, 4'd12, 1'b1, "q_wall_row");
    query(4'd15, 4'd15, 1'b1, "q_wall_corner");

    plot_px(8'd160, 7'd10, 3'b111);
    plot_px(8'd10, 7'd120, 3'b111);
    check("occ_oob_writes", 32'(occ_count), occ_exp(0));
    query(4'd0, 4'd2, 1'b0, "q02_no_wrap");

    // write and query capture on the same cell at the same edge
    x = 8'd0; y = 7'd0; colour = 3'b100; plot = 1'b1;
    q_cx = 4'd0; q_cy = 4'd0; q_req = 1'b1;
    exp_q.push_back(32'd0);
    @(posedge CLOCK_50); #1;
    plot = 1'b0;
    wait_ack("q00_read_old", lat);
    check("q00_read_old_lat", 32'(lat), 32'd1);
    finish_query("q00_read_old");
    query(4'd0, 4'd0, 1'b1, "q00_after");
    check("occ_one_again", 32'(occ_count), occ_exp(1));

    plot_px(8'd22, 7'd22, 3'b001);
    plot_px(8'd15, 7'd15, 3'b011);
    plot_px(8'd159, 7'd119, 3'b101);
    plot_px(8'd0, 7'd119, 3'b110);
    check("occ_five", 32'(occ_count), occ_exp(5));
    query(4'd15, 4'd11, 1'b1, "q_last_cell");
    query(4'd2, 4'd2, 1'b1, "q22_set");

    // clear with a query held through it
    clr = 1'b1; q_cx = 4'd2; q_cy = 4'd2; q_req = 1'b1;
    exp_q.push_back(32'd0);
    @(posedge CLOCK_50); #1;
    clr = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_occ_first", 32'(occ_count), 32'd0);
    count_busy(1'b1, n);
    check("clr_busy_len", 32'(n), 32'd192);
    check("clr_no_early_ack", 32'(q_ack), 32'd0);
    wait_ack("clr_q22", lat);
    check("clr_q22_lat", 32'(lat), 32'd1);
    finish_query("clr_q22");
    check("clr_occ_after", 32'(occ_count), 32'd0);
    query(4'd0, 4'd0, 1'b0, "q00_cleared");
    query(4'd15, 4'd11, 1'b0, "q_last_cleared");

    // reset in the middle of a clear restarts the full sweep
    plot_px(8'd40, 7'd40, 3'b010);
    clr = 1'b1;
    @(posedge CLOCK_50); #1;
    clr = 1'b0;
    repeat (50) @(posedge CLOCK_50);
    #1;
    resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    check("midrst_busy", 32'(busy), 32'd1);
    count_busy(1'b0, n);
    check("midrst_busy_len", 32'(n), 32'd192);
    @(posedge CLOCK_50); #1;
    query(4'd4, 4'd4, 1'b0, "q44_after_reset");
    check("occ_final", 32'(occ_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
